// File: rtl/seq_alu_if.sv
// -----------------------------------------------------------------------------
// seq_alu_if
// Request/response bundle for the sequential ALU.
//   start  : request, sampled only while busy is low
//   A, B   : unsigned WIDTH-bit operands
//   ctrl   : opcode (00 add, 01 sub, 10 mul, 11 div or AND)
//   busy   : multi-cycle operation in progress
//   done   : one-cycle completion pulse
//   result : registered 2*WIDTH-bit result
//   zero   : result == 0
//   neg    : subtract went negative
//   dz     : divide by zero
// master = requester (front-end / bench), slave = the ALU.
// -----------------------------------------------------------------------------
interface seq_alu_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic [1:0]           ctrl;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   result;
    logic                 zero;
    logic                 neg;
    logic                 dz;

    modport master (
        output start, A, B, ctrl,
        input  busy, done, result, zero, neg, dz
    );

    modport slave (
        input  start, A, B, ctrl,
        output busy, done, result, zero, neg, dz
    );
endinterface

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
// Multi-cycle ALU with a start/done handshake. Add and subtract finish in one
// cycle straight from IDLE; multiply runs a WIDTH-cycle shift-add loop in EXEC.
//
// Optional feature macro: ALU_DIV_EN
//   defined   : ctrl=11 is a WIDTH-cycle unsigned restoring divide,
//               result = {remainder, quotient}, dz live.
//   undefined : ctrl=11 is a single-cycle bitwise AND, dz tied 0.
//
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : seq_alu_if.slave (start, A, B, ctrl in; busy, done, result,
//         zero, neg, dz out -- all outputs registered)
// -----------------------------------------------------------------------------
module seq_alu #(
    parameter int WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    seq_alu_if.slave    bus
);

    localparam int RW    = 2 * WIDTH;
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;

    logic               r_busy;
    logic               r_done;
    logic [RW-1:0]      r_result;
    logic               r_zero;
    logic               r_neg;
    logic               r_dz;

    // Iterative datapath: r_acc is the product accumulator for multiply and
    // {remainder, quotient/dividend} for divide.
    logic [RW-1:0]      r_acc;
    logic [RW-1:0]      r_mcand;
    logic [WIDTH-1:0]   r_mplier;

    logic               w_accept;
    logic               w_is_multi;
    logic               w_last;
    logic [RW-1:0]      w_mul_acc;
    logic [RW-1:0]      w_acc_next;

    logic               w_load;
    logic [RW-1:0]      w_res_next;
    logic               w_neg_next;
    logic               w_dz_next;

`ifdef ALU_DIV_EN
    logic [WIDTH-1:0]   r_b;
    logic [1:0]         r_op;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [RW-1:0]      w_div_acc;
`endif

    // Single-cycle operations. Subtract wraps in 2*WIDTH bits, which is
    // exactly the sign extension of the WIDTH+1-bit difference.
    function automatic logic [RW-1:0] f_single(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [1:0]       op
    );
        logic [RW-1:0] res;
        case (op)
            2'b00:   res = RW'(a) + RW'(b);
            2'b01:   res = RW'(a) - RW'(b);
            default: res = RW'(a & b);
        endcase
        return res;
    endfunction

    assign w_accept = bus.start && (r_state == S_IDLE);
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef ALU_DIV_EN
    assign w_is_multi = bus.ctrl[1];
`else
    assign w_is_multi = (bus.ctrl == 2'b10);
`endif

    // Shift-add step: add the shifted multiplicand when the current
    // multiplier LSB is set.
    assign w_mul_acc = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

`ifdef ALU_DIV_EN
    // Restoring step: bring the next dividend bit into the partial remainder
    // and subtract B when it fits. With B=0 every step "fits", giving an
    // all-ones quotient and a remainder equal to A.
    assign w_shift   = {r_acc[RW-1:WIDTH], r_acc[WIDTH-1]};
    assign w_ge      = (w_shift >= {1'b0, r_b});
    assign w_diff    = w_shift - {1'b0, r_b};
    assign w_div_acc = {(w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0]),
                        r_acc[WIDTH-2:0], w_ge};
    assign w_acc_next = (r_op == 2'b11) ? w_div_acc : w_mul_acc;
`else
    assign w_acc_next = w_mul_acc;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept && w_is_multi) w_state_next = S_EXEC;
            S_EXEC: if (w_last)                 w_state_next = S_IDLE;
            default:                            w_state_next = S_IDLE;
        endcase
    end

    // FSM output logic: decides when and what to load into the result
    // registers.
    always_comb begin
        w_load     = 1'b0;
        w_res_next = r_result;
        w_neg_next = r_neg;
        w_dz_next  = r_dz;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !w_is_multi) begin
                    w_load     = 1'b1;
                    w_res_next = f_single(bus.A, bus.B, bus.ctrl);
                    w_neg_next = (bus.ctrl == 2'b01) && (bus.A < bus.B);
                    w_dz_next  = 1'b0;
                end
            end
            S_EXEC: begin
                if (w_last) begin
                    w_load     = 1'b1;
                    w_res_next = w_acc_next;
                    w_neg_next = 1'b0;
`ifdef ALU_DIV_EN
                    w_dz_next  = (r_op == 2'b11) && (r_b == '0);
`else
                    w_dz_next  = 1'b0;
`endif
                end
            end
            default: ;
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_neg    <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            if (r_state == S_EXEC && !w_last) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
            r_busy <= (w_state_next == S_EXEC);
            r_done <= w_load;
            if (w_load) begin
                r_result <= w_res_next;
                r_zero   <= (w_res_next == '0);
                r_neg    <= w_neg_next;
                r_dz     <= w_dz_next;
            end
        end
    end

    // Iterative datapath: loaded on acceptance, stepped once per EXEC cycle.
    // Operands are captured here so later input changes cannot disturb it.
    always_ff @(posedge clk) begin
        if (w_accept && w_is_multi) begin
            r_mcand  <= RW'(bus.A);
            r_mplier <= bus.B;
`ifdef ALU_DIV_EN
            r_b      <= bus.B;
            r_op     <= bus.ctrl;
            r_acc    <= (bus.ctrl == 2'b11) ? RW'(bus.A) : '0;
`else
            r_acc    <= '0;
`endif
        end else if (r_state == S_EXEC) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.zero   = r_zero;
    assign bus.neg    = r_neg;
    assign bus.dz     = r_dz;

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu
// Directed testbench for seq_alu at WIDTH=4. Covers both builds: divide
// vectors when ALU_DIV_EN is defined, the AND vector otherwise.
// -----------------------------------------------------------------------------
module tb_seq_alu;

    localparam int WIDTH = 4;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    seq_alu_if #(.WIDTH(WIDTH)) bus_if ();

    seq_alu #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle (cycle 0), then scramble the operands
    // so an operation in flight must rely on its own captured copies.
    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [1:0] c);
        bus_if.start = 1'b1;
        bus_if.A     = a;
        bus_if.B     = b;
        bus_if.ctrl  = c;
        step();
        bus_if.start = 1'b0;
        bus_if.A     = a ^ 4'hA;
        bus_if.B     = b ^ 4'h5;
        bus_if.ctrl  = 2'b00;
    endtask

    task automatic op_single(input string tag, input logic [3:0] a, input logic [3:0] b,
                             input logic [1:0] c, input logic [7:0] exp_res,
                             input logic exp_zero, input logic exp_neg);
        issue(a, b, c);
        chk({tag, ".done"},   32'(bus_if.done),   32'd1);
        chk({tag, ".busy"},   32'(bus_if.busy),   32'd0);
        chk({tag, ".result"}, 32'(bus_if.result), 32'(exp_res));
        chk({tag, ".zero"},   32'(bus_if.zero),   32'(exp_zero));
        chk({tag, ".neg"},    32'(bus_if.neg),    32'(exp_neg));
        chk({tag, ".dz"},     32'(bus_if.dz),     32'd0);
        step();
        chk({tag, ".pulse"},  32'(bus_if.done),   32'd0);
    endtask

    task automatic op_multi(input string tag, input logic [3:0] a, input logic [3:0] b,
                            input logic [1:0] c, input logic [7:0] exp_res,
                            input logic exp_zero, input logic exp_dz);
        issue(a, b, c);
        for (int i = 1; i <= WIDTH; i++) begin
            chk($sformatf("%s.busy_c%0d", tag, i), 32'(bus_if.busy), 32'd1);
            chk($sformatf("%s.done_c%0d", tag, i), 32'(bus_if.done), 32'd0);
            step();
        end
        chk({tag, ".done"},   32'(bus_if.done),   32'd1);
        chk({tag, ".busy"},   32'(bus_if.busy),   32'd0);
        chk({tag, ".result"}, 32'(bus_if.result), 32'(exp_res));
        chk({tag, ".zero"},   32'(bus_if.zero),   32'(exp_zero));
        chk({tag, ".neg"},    32'(bus_if.neg),    32'd0);
        chk({tag, ".dz"},     32'(bus_if.dz),     32'(exp_dz));
        step();
        chk({tag, ".pulse"},  32'(bus_if.done),   32'd0);
    endtask

    initial begin
        n_total      = 0;
        n_pass       = 0;
        rst          = 1'b1;
        bus_if.start = 1'b0;
        bus_if.A     = '0;
        bus_if.B     = '0;
        bus_if.ctrl  = 2'b00;
        step();
        step();
        chk("rst.busy",   32'(bus_if.busy),   32'd0);
        chk("rst.done",   32'(bus_if.done),   32'd0);
        chk("rst.result", 32'(bus_if.result), 32'd0);
        chk("rst.zero",   32'(bus_if.zero),   32'd1);
        chk("rst.neg",    32'(bus_if.neg),    32'd0);
        chk("rst.dz",     32'(bus_if.dz),     32'd0);
        rst = 1'b0;
        step();

        // Single-cycle add / subtract
        op_single("add6_3", 4'd6, 4'd3, 2'b00, 8'h09, 1'b0, 1'b0);
        op_single("add15_15", 4'd15, 4'd15, 2'b00, 8'h1E, 1'b0, 1'b0);
        op_single("sub6_3", 4'd6, 4'd3, 2'b01, 8'h03, 1'b0, 1'b0);
        op_single("sub3_6", 4'd3, 4'd6, 2'b01, 8'hFD, 1'b0, 1'b1);
        op_single("sub5_5", 4'd5, 4'd5, 2'b01, 8'h00, 1'b1, 1'b0);
        op_single("sub0_15", 4'd0, 4'd15, 2'b01, 8'hF1, 1'b0, 1'b1);

        // Multiply
        op_multi("mul6_3", 4'd6, 4'd3, 2'b10, 8'h12, 1'b0, 1'b0);
        op_multi("mul15_15", 4'd15, 4'd15, 2'b10, 8'hE1, 1'b0, 1'b0);
        op_multi("mul0_9", 4'd0, 4'd9, 2'b10, 8'h00, 1'b1, 1'b0);

`ifdef ALU_DIV_EN
        op_multi("div13_4", 4'd13, 4'd4, 2'b11, 8'h13, 1'b0, 1'b0);
        op_multi("div9_0", 4'd9, 4'd0, 2'b11, 8'h9F, 1'b0, 1'b1);
        op_multi("div15_15", 4'd15, 4'd15, 2'b11, 8'h01, 1'b0, 1'b0);
`else
        op_single("and12_10", 4'd12, 4'd10, 2'b11, 8'h08, 1'b0, 1'b0);
        op_single("and5_10", 4'd5, 4'd10, 2'b11, 8'h00, 1'b1, 1'b0);
`endif

        // Start while busy is ignored; back-to-back accept on the done cycle
        issue(4'd6, 4'd3, 2'b10);
        chk("hs.busy_c1", 32'(bus_if.busy), 32'd1);
        chk("hs.done_c1", 32'(bus_if.done), 32'd0);
        step();
        for (int i = 2; i <= 3; i++) begin
            bus_if.start = 1'b1;
            bus_if.A     = 4'd1;
            bus_if.B     = 4'd1;
            bus_if.ctrl  = 2'b00;
            chk($sformatf("hs.busy_c%0d", i), 32'(bus_if.busy), 32'd1);
            chk($sformatf("hs.done_c%0d", i), 32'(bus_if.done), 32'd0);
            step();
        end
        bus_if.start = 1'b0;
        chk("hs.busy_c4", 32'(bus_if.busy), 32'd1);
        chk("hs.done_c4", 32'(bus_if.done), 32'd0);
        step();
        chk("hs.done_c5",   32'(bus_if.done),   32'd1);
        chk("hs.busy_c5",   32'(bus_if.busy),   32'd0);
        chk("hs.result_c5", 32'(bus_if.result), 32'h12);
        issue(4'd2, 4'd5, 2'b00);
        chk("hs.done_c6",   32'(bus_if.done),   32'd1);
        chk("hs.result_c6", 32'(bus_if.result), 32'h07);
        step();
        chk("hs.pulse_c7",  32'(bus_if.done),   32'd0);

        // Reset in the middle of a multiply
        issue(4'd15, 4'd15, 2'b10);
        step();
        step();
        rst = 1'b1;
        step();
        chk("mrst.busy",   32'(bus_if.busy),   32'd0);
        chk("mrst.done",   32'(bus_if.done),   32'd0);
        chk("mrst.result", 32'(bus_if.result), 32'd0);
        chk("mrst.zero",   32'(bus_if.zero),   32'd1);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("mrst.nodone%0d", i), 32'(bus_if.done), 32'd0);
        end
        op_single("mrst.add2_2", 4'd2, 4'd2, 2'b00, 8'h04, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, multi-cycle successor to the lab's 4-bit combinational ALU. It accepts a WIDTH-bit operand pair and a 2-bit opcode under a start/done handshake and returns a registered 2*WIDTH-bit result plus status flags. Add and subtract complete in one cycle. Multiply (and divide, when enabled) run an iterative shift-add / restoring datapath over WIDTH cycles. It sits between the board's switch/button front-end and the seven-segment result display.

## Interface
- WIDTH, 4: operand width in bits; legal range is 2 to 16.
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while busy=0.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- ctrl  input  2  opcode: 00 add, 01 subtract, 10 multiply, 11 divide (or AND; see Configuration).
- busy  output  1  high while a multi-cycle operation is in progress.
- done  output  1  one-cycle pulse; result and flags updated on the same edge.
- result  output  2*WIDTH  registered result; held until the next completion.
- zero  output  1  result == 0, registered with result.
- neg  output  1  subtract produced a negative value (A < B).
- dz  output  1  divide-by-zero occurred (divide build only; otherwise tied 0).

## Operation
- States are IDLE and EXEC.
- In IDLE with start=1, A, B and ctrl are latched.
- **Add:** result = zero-extended A + B; bit WIDTH carries out.
- **Subtract:** result = A − B, two's complement, sign-extended to 2*WIDTH. Example: 3−6 gives 8'hFD at WIDTH=4, and neg=1.
- **Add and subtract:** both complete directly from IDLE; the FSM stays in IDLE.
- **Multiply:** unsigned shift-add.
  - The FSM enters EXEC and runs WIDTH iterations, one per cycle.
  - Iteration counter runs 0..WIDTH−1.
  - Accumulator is 2*WIDTH bits and cannot overflow.
- **Divide:** unsigned restoring division, WIDTH iterations.
  - result = {remainder, quotient}: remainder in the high half, quotient in the low half.
  - If B=0: quotient = all ones, remainder = A, dz=1. The operation still takes the full latency.
- **Flags:**
  - zero is computed on the final result value.
  - neg = 0 for every operation except subtract.
  - dz = 0 except on divide by B=0.
- Operand and ctrl changes after acceptance have no effect on an operation in flight.
- start while busy=1 is ignored. It is neither queued nor an error.
- **Reset** (at any time, including mid-EXEC):
  - FSM returns to IDLE and the iteration counter clears.
  - busy=0, done=0, result=0, zero=1, neg=0, dz=0.
  - The in-flight operation is discarded and no done is issued.

## Timing
- Cycle 0 is the cycle in which start=1 is sampled with busy=0.
- **Add/sub (and AND):** done=1 in cycle 1, result valid from cycle 1. busy stays 0.
- **Multiply/divide:**
  - busy=1 in cycles 1..WIDTH.
  - done=1 and busy=0 in cycle WIDTH+1; result valid from cycle WIDTH+1.
  - Latency is WIDTH+1, which is 5 at WIDTH=4.
- done is high for exactly one cycle per accepted start.
- A new start may be accepted in the same cycle done is high, since busy=0 there. That gives back-to-back throughput of one op per (latency) cycles.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- ALU_DIV_EN defined:
  - ctrl=11 is the iterative unsigned divide described above.
  - dz is live.
- ALU_DIV_EN undefined:
  - ctrl=11 is single-cycle bitwise AND: result = {WIDTH'b0, A & B}, done in cycle 1, busy stays 0.
  - Divider datapath is removed; dz is tied 0.

## Test plan
All cases at WIDTH=4.
- **Add/sub:**
  - A=6, B=3, ctrl=00 → done in cycle 1, result=8'h09, zero=0.
  - A=6, B=3, ctrl=01 → result=8'h03, neg=0.
  - A=3, B=6, ctrl=01 → result=8'hFD, neg=1.
  - A=B=5, ctrl=01 → result=0, zero=1.
- **Multiply:**
  - A=6, B=3, ctrl=10 → busy=1 cycles 1–4, done in cycle 5, result=8'h12.
  - A=B=15 → result=8'hE1.
  - A=0 → result=0, zero=1.
- **Divide (ALU_DIV_EN):**
  - A=13, B=4 → done in cycle 5, result=8'h13 (r=1, q=3).
  - A=9, B=0 → result=8'h9F, dz=1.
  - Build without ALU_DIV_EN: A=12, B=10, ctrl=11 → cycle-1 result=8'h08.
- **Handshake:**
  - Multiply accepted, then start pulsed with ctrl=00 in cycles 2 and 3 → ignored, single done in cycle 5 with the multiply result.
  - New add accepted in cycle 5 → done in cycle 6.
- **Reset mid-operation:**
  - Assert rst in cycle 3 of a multiply → next cycle busy=0, done=0, result=0, zero=1.
  - No done pulse follows.
  - A subsequent add of 2+2 returns 8'h04 in one cycle.
